// File: rtl/vga_screen_pkg.sv
// -----------------------------------------------------------------------------
// vga_screen_pkg
// Purpose : Screen/state codes shared by the screen sequencer and the VGA
//           output multiplexer, plus the sequencer state type.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_screen_pkg;

  // Screen select codes consumed by the VGA multiplexer.
  localparam logic [2:0] SCR_OFF   = 3'd0;
  localparam logic [2:0] SCR_INTRO = 3'd1;
  localparam logic [2:0] SCR_GAME  = 3'd2;
  localparam logic [2:0] SCR_END   = 3'd3;

  // The state encoding is the screen code itself, so the state register
  // drives vga_control directly.
  typedef enum logic [2:0] {
    ST_OFF   = SCR_OFF,
    ST_INTRO = SCR_INTRO,
    ST_GAME  = SCR_GAME,
    ST_END   = SCR_END
  } state_t;

endpackage

// File: rtl/vga_screen_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Purpose : 2-flop synchronizer, stability counter and debounced level for a
//           raw mechanical button, plus a one-cycle pulse on each debounced
//           rising edge.
// Ports   : clk        system clock
//           clr        asynchronous active-high reset
//           btn_raw    raw asynchronous button input
//           rise_pulse one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg, sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          level_d_reg;
  logic          pulse_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  // Edge detect on the debounced level, registered so the pulse is a clean
  // flop output one cycle after the level flips.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level_d_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      level_d_reg <= level_reg;
      pulse_reg   <= level_reg & ~level_d_reg;
    end
  end

  assign rise_pulse = pulse_reg;

endmodule

// File: rtl/vga_screen_ctrl.sv
// -----------------------------------------------------------------------------
// vga_screen_ctrl
// Purpose : Screen sequencer in front of the VGA multiplexer. Runs the
//           OFF/INTRO/GAME/END flow, times the intro blink and debounces the
//           start button.
// Build   : define END_TIMEOUT_EN to auto-return from END to INTRO after
//           END_HOLD_CYCLES cycles; otherwise END waits for a button press.
// Ports   : clk         system clock
//           clr         asynchronous active-high reset
//           en          display enable (level)
//           btn_start   raw start button
//           game_over   one-cycle pulse from the game core
//           vga_control screen select (0 blank, 1 intro, 2 game, 3 end)
//           blink       intro blink flag, 1 = blank phase
//           game_run    high while in GAME
//           start_pulse one-cycle pulse per debounced press
// -----------------------------------------------------------------------------
module vga_screen_ctrl
  import vga_screen_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES = 50_000_000,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int END_HOLD_CYCLES   = 300_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       btn_start,
  input  logic       game_over,
  output logic [2:0] vga_control,
  output logic       blink,
  output logic       game_run,
  output logic       start_pulse
);

  // Reject unusable parameter values at elaboration.
  if (BLINK_HALF_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || END_HOLD_CYCLES < 1) begin : g_param_check
    $error("vga_screen_ctrl: invalid timing parameter");
  end

  localparam int BW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  state_t        state_reg, state_next;
  logic          game_run_reg, game_run_next;
  logic          blink_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_run;
  logic          end_done;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .clr       (clr),
    .btn_raw   (btn_start),
    .rise_pulse(start_pulse)
  );

`ifdef END_TIMEOUT_EN
  localparam int EW = $clog2(END_HOLD_CYCLES + 1);
  localparam logic [EW-1:0] END_LAST = EW'(END_HOLD_CYCLES - 1);

  logic [EW-1:0] end_cnt_reg;

  // Zero whenever END is not being held, so it starts at 0 on every entry.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      end_cnt_reg <= '0;
    end else if (state_reg == ST_END && state_next == ST_END) begin
      end_cnt_reg <= end_cnt_reg + 1'b1;
    end else begin
      end_cnt_reg <= '0;
    end
  end

  assign end_done = (state_reg == ST_END) && (end_cnt_reg == END_LAST);
`else
  assign end_done = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_OFF;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; losing enable overrides every other event.
  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = ST_OFF;
    end else begin
      case (state_reg)
        ST_OFF:   state_next = ST_INTRO;
        ST_INTRO: if (start_pulse) state_next = ST_GAME;
        ST_GAME:  if (game_over) state_next = ST_END;
        ST_END:   if (start_pulse || end_done) state_next = ST_INTRO;
        default:  state_next = ST_OFF;
      endcase
    end
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    game_run_next = (state_next == ST_GAME);
    // Blink only advances while INTRO is both current and next state, which
    // clears it on entry and forces it low the cycle INTRO is left.
    blink_run     = (state_reg == ST_INTRO) && (state_next == ST_INTRO);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      game_run_reg  <= 1'b0;
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
    end else begin
      game_run_reg <= game_run_next;
      if (!blink_run) begin
        blink_reg     <= 1'b0;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink_reg     <= ~blink_reg;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign vga_control = state_reg;
  assign blink       = blink_reg;
  assign game_run    = game_run_reg;

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_screen_ctrl
// Directed sequence for vga_screen_ctrl with small timing parameters
// (blink half-period 4, debounce 3, end hold 10). Expected screen outputs and
// expected start_pulse cycles are queued as stimulus is applied and checked
// when the DUT responds.
// -----------------------------------------------------------------------------
module tb_vga_screen_ctrl;
  import vga_screen_pkg::*;

  logic       clk = 1'b0;
  logic       clr, en, btn_start, game_over;
  logic [2:0] vga_control;
  logic       blink, game_run, start_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string      tag;
    logic [2:0] vc;
    logic       bl;
    logic       care_bl;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_screen_ctrl #(
    .BLINK_HALF_CYCLES(4),
    .DEBOUNCE_CYCLES  (3),
    .END_HOLD_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .btn_start  (btn_start),
    .game_over  (game_over),
    .vga_control(vga_control),
    .blink      (blink),
    .game_run   (game_run),
    .start_pulse(start_pulse)
  );

  // Every observed start_pulse must match the oldest queued press time.
  always @(negedge clk) begin
    int exp_c;
    if (!clr && start_pulse === 1'b1) begin
      exp_c = (pulse_q.size() != 0) ? pulse_q.pop_front() : -1;
      checks++;
      assert (cyc == exp_c) else begin
        failures++;
        $error("FAIL start_pulse_time: pulse at cycle %0d, expected cycle %0d", cyc, exp_c);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] vc,
                            input logic bl, input logic care_bl, input logic run);
    exp_t e;
    e.tag = tag; e.vc = vc; e.bl = bl; e.care_bl = care_bl; e.run = run;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    assert (vga_control === e.vc && game_run === e.run &&
            (!e.care_bl || blink === e.bl)) else begin
      failures++;
      $error("FAIL %s: vga_control=%0d blink=%b game_run=%b, expected %0d/%b/%b",
             e.tag, vga_control, blink, game_run, e.vc, e.bl, e.run);
    end
  endtask

  // Clean press: the pulse is due 6 cycles after the raw edge.
  task automatic press(input int hold);
    btn_start = 1'b1;
    pulse_q.push_back(cyc + 6);
    step(hold);
    btn_start = 1'b0;
    step(8);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; btn_start = 1'b0; game_over = 1'b0;
    step(2);
    expect_out("reset", SCR_OFF, 1'b0, 1'b1, 1'b0);
    check_out();

    // Release reset with enable high: INTRO one cycle later.
    clr = 1'b0; en = 1'b1;
    expect_out("intro_entry", SCR_INTRO, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out();

    // Blink pattern 0000 1111 0000 ...
    for (int i = 0; i < 20; i++) begin
      expect_out("blink", SCR_INTRO, ((i / 4) % 2) == 1, 1'b1, 1'b0);
      check_out();
      step(1);
    end

    // Press -> GAME, blink forced low.
    press(10);
    expect_out("intro_to_game", SCR_GAME, 1'b0, 1'b1, 1'b1);
    check_out();

    // Bouncy 2-cycle glitches: no pulse, no state change.
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(2);
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(10);
    expect_out("glitch_ignored", SCR_GAME, 1'b0, 1'b1, 1'b1);
    check_out();

    // A press in GAME pulses but does not change state.
    press(10);
    expect_out("start_ignored_game", SCR_GAME, 1'b0, 1'b1, 1'b1);
    check_out();

    // game_over -> END next cycle.
    game_over = 1'b1;
    expect_out("game_over_end", SCR_END, 1'b0, 1'b1, 1'b0);
    step(1);
    game_over = 1'b0;
    check_out();

`ifdef END_TIMEOUT_EN
    expect_out("end_hold", SCR_END, 1'b0, 1'b1, 1'b0);
    step(9);
    check_out();
    expect_out("end_timeout", SCR_INTRO, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out();
`else
    for (int i = 0; i < 10; i++) begin
      expect_out("end_stays", SCR_END, 1'b0, 1'b1, 1'b0);
      step(10);
      check_out();
    end
    press(10);
    expect_out("end_exit_press", SCR_INTRO, 1'b0, 1'b0, 1'b0);
    check_out();
`endif

    // game_over in INTRO is dropped.
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    expect_out("game_over_ignored_intro", SCR_INTRO, 1'b0, 1'b0, 1'b0);
    step(3);
    check_out();

    press(10);
    expect_out("intro_to_game2", SCR_GAME, 1'b0, 1'b1, 1'b1);
    check_out();

    // Enable loss wins over a simultaneous game_over.
    en = 1'b0; game_over = 1'b1;
    expect_out("en_off_priority", SCR_OFF, 1'b0, 1'b1, 1'b0);
    step(1);
    game_over = 1'b0;
    check_out();
    expect_out("off_holds", SCR_OFF, 1'b0, 1'b1, 1'b0);
    step(3);
    check_out();

    en = 1'b1;
    expect_out("reenable_intro", SCR_INTRO, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out();
    expect_out("reenable_not_end", SCR_INTRO, 1'b0, 1'b0, 1'b0);
    step(2);
    check_out();

    // Asynchronous clear in the middle of GAME.
    press(10);
    expect_out("intro_to_game3", SCR_GAME, 1'b0, 1'b1, 1'b1);
    check_out();
    #2 clr = 1'b1;
    expect_out("clr_async", SCR_OFF, 1'b0, 1'b1, 1'b0);
    #1 check_out();
    step(1);
    clr = 1'b0;
    expect_out("clr_release_intro", SCR_INTRO, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out();

    step(10);
    checks++;
    assert (pulse_q.size() == 0) else begin
      failures++;
      $error("FAIL pulse_missing: %0d expected pulses not seen, expected 0", pulse_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_screen_ctrl.md
Name: vga_screen_ctrl

Overview:
- Screen-sequencing controller directly upstream of the VGA output multiplexer.
- Produces the 3-bit screen select (0 = blank, 1 = intro, 2 = game, 3 = end screen) and the intro-screen blink flag that the multiplexer consumes.
- Debounces the player start button, tracks game-over from the game core, and times the blink and end-screen hold.

Parameters:
- BLINK_HALF_CYCLES, 50_000_000: clk cycles per blink half-period (0.5 s at 100 MHz); must be >= 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a new button level; must be >= 1.
- END_HOLD_CYCLES, 300_000_000: clk cycles the end screen is held before auto-return (used only with END_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; the only clock.
- clr  in  1  reset; asynchronous, active-high.
- en  in  1  display enable; level.
- btn_start  in  1  raw, asynchronous, bouncy start button; active-high.
- game_over  in  1  single-cycle pulse from the game core, synchronous to clk.
- vga_control  out  3  screen select to the multiplexer.
- blink  out  1  intro blink flag; 1 = blank phase.
- game_run  out  1  high while in GAME; enables the game core.
- start_pulse  out  1  one-cycle pulse on each debounced rising edge of btn_start.

Behaviour:
- Reset (clr=1, asynchronous): state=OFF, vga_control=0, blink=0, game_run=0, start_pulse=0; all counters 0; synchronizer flops and debounced level 0. Release is synchronous to the next clk edge.
- All outputs are registered. vga_control equals the state code.
- Button path: 2-flop synchronizer -> debouncer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive cycles with the synchronized input differing from the current debounced level.
  - Any disagreeing gap restarts the count.
  - start_pulse = 1 for exactly one cycle on a debounced 0->1 edge.
  - Latency from a clean raw edge to start_pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states and codes: OFF=0, INTRO=1, GAME=2, END=3. Transitions take effect on the clk edge after the qualifying event.
  - Any state, en=0 -> OFF. This has highest priority over every other event.
  - OFF, en=1 -> INTRO.
  - INTRO, start_pulse -> GAME. game_over is ignored in INTRO.
  - GAME, game_over -> END. start_pulse is ignored in GAME.
  - END, start_pulse -> INTRO.
- Blink:
  - The counter runs only in INTRO.
  - On entry to INTRO: counter=0 and blink=0.
  - When the counter reaches BLINK_HALF_CYCLES-1, blink toggles and the counter wraps to 0.
  - Outside INTRO, blink=0 and the counter is held at 0.
- game_run = 1 exactly when the registered state is GAME.
- Simultaneous events:
  - en falling together with start_pulse or game_over -> OFF; the event is dropped.
  - start_pulse and END timeout in the same cycle -> INTRO, taken once.
- A button held through a state change does not re-trigger; a new release and press is required.
- No stored events: a game_over pulse outside GAME is lost.

Optional Feature:
- Macro: END_TIMEOUT_EN.
- Defined:
  - An END hold counter clears on entry to END and increments each cycle in END.
  - When it reaches END_HOLD_CYCLES-1, the FSM goes to INTRO.
  - start_pulse still exits early.
- Undefined: END exits only on start_pulse or en=0; no hold counter is built; END_HOLD_CYCLES is unused.

Decomposition:
- Package vga_screen_pkg:
  - State/screen code constants SCR_OFF=3'd0, SCR_INTRO=3'd1, SCR_GAME=3'd2, SCR_END=3'd3, shared with the multiplexer.
  - State typedef.
- Sub-module btn_debounce: synchronizer, stable counter, debounced level, rising-edge pulse; parameter DEBOUNCE_CYCLES.
- FSM, blink timer and end timer stay in vga_screen_ctrl.

Test Plan:
(All scenarios use BLINK_HALF_CYCLES=4, DEBOUNCE_CYCLES=3, END_HOLD_CYCLES=10.)
1. Reset/enable: assert clr mid-GAME -> outputs immediately 0/OFF. Release clr with en=1 -> vga_control=1 one cycle later, blink=0.
2. Blink: hold INTRO 20 cycles -> blink toggles every 4 cycles (0000 1111 0000 ...). start_pulse -> GAME, blink=0, game_run=1.
3. Debounce: raw btn pulses 1,0,1,0 at 2-cycle spacing -> no start_pulse. Clean press held 10 cycles -> exactly one start_pulse, 6 cycles after the raw edge.
4. Game flow: INTRO -> press -> GAME. game_over pulse -> END (vga_control=3) next cycle. game_over while in INTRO -> no change.
5. END exit: with END_TIMEOUT_EN, idle in END -> INTRO after 10 cycles. Without it, state stays END for 100 cycles until a press.
6. Priority: en=0 in the same cycle as game_over in GAME -> OFF, game_run=0. en=1 again -> INTRO, not END.
